// File: rtl/muldiv_unit_pkg.sv
// Shared define file for the integer datapath: ALU and multiply/divide opcodes,
// MDU state encoding and the iteration count of the multiply/divide engines.
package muldiv_unit_pkg;

    localparam int MDU_ITERS = 32;
    localparam int MDU_CNT_W = $clog2(MDU_ITERS + 1);

    localparam logic [3:0] ALUOp_ADD = 4'd0;
    localparam logic [3:0] ALUOp_SUB = 4'd1;
    localparam logic [3:0] ALUOp_AND = 4'd2;
    localparam logic [3:0] ALUOp_OR  = 4'd3;
    localparam logic [3:0] ALUOp_XOR = 4'd4;
    localparam logic [3:0] ALUOp_NOR = 4'd5;
    localparam logic [3:0] ALUOp_SLT = 4'd6;
    localparam logic [3:0] ALUOp_SLL = 4'd7;

    typedef enum logic [2:0] {
        MDUOp_MULT  = 3'd0,
        MDUOp_MULTU = 3'd1,
        MDUOp_DIV   = 3'd2,
        MDUOp_DIVU  = 3'd3,
        MDUOp_MTHI  = 3'd4,
        MDUOp_MTLO  = 3'd5,
        MDUOp_MADD  = 3'd6,
        MDUOp_MSUB  = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_e;

    // Magnitude of a two's-complement value when the operation is signed.
    function automatic logic [31:0] mdu_mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional MADD/MSUB accumulate enabled by defining MDU_MADD_EN.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] Src1,
    input  logic [31:0] Src2,
    input  logic        Flush,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    mdu_state_e            state_q, state_d;
    mdu_op_e               op_in, op_q;
    logic [MDU_CNT_W-1:0]  cnt_q;
    logic [31:0]           acc_q;   // partial product high / partial remainder
    logic [31:0]           quo_q;   // multiplier shifting out / quotient shifting in
    logic [31:0]           opa_q;   // multiplicand / divisor magnitude
    logic                  s1n_q, s2n_q, dz_q, done_q;

    logic                  start_ok, go_mul, go_div, signed_in, cnt_last, is_acc_q;
    logic [32:0]           add_a, add_b;
    logic                  add_ci;
    logic [33:0]           add_s;
    logic [63:0]           prod, prod_fix;

    assign op_in     = mdu_op_e'(Op);
    assign start_ok  = Start && !Flush && (state_q == ST_IDLE);
    assign cnt_last  = (cnt_q == MDU_CNT_W'(MDU_ITERS));
    assign signed_in = (op_in == MDUOp_MULT) || (op_in == MDUOp_DIV) ||
                       (op_in == MDUOp_MADD) || (op_in == MDUOp_MSUB);
    assign go_div    = (op_in == MDUOp_DIVU) || (op_in == MDUOp_DIV);
`ifdef MDU_MADD_EN
    assign go_mul    = (op_in == MDUOp_MULT) || (op_in == MDUOp_MULTU) ||
                       (op_in == MDUOp_MADD) || (op_in == MDUOp_MSUB);
    assign is_acc_q  = (op_q == MDUOp_MADD) || (op_q == MDUOp_MSUB);
`else
    assign go_mul    = (op_in == MDUOp_MULT) || (op_in == MDUOp_MULTU);
    assign is_acc_q  = 1'b0;
`endif

    assign Busy = (state_q != ST_IDLE);
    assign Done = done_q;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok && go_mul)      state_d = ST_MUL;
                else if (start_ok && go_div) state_d = ST_DIV;
            end
            ST_MUL:  if (cnt_last) state_d = is_acc_q ? ST_FIX : ST_IDLE;
            ST_DIV:  if (cnt_last) state_d = ST_FIX;
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (Flush) state_d = ST_IDLE;
    end

    // One 33-bit adder: conditional add of the multiplicand, or trial subtract
    // of the divisor where the carry-out means "no borrow".
    always_comb begin
        add_a  = {1'b0, acc_q};
        add_b  = quo_q[0] ? {1'b0, opa_q} : 33'd0;
        add_ci = 1'b0;
        if (state_q == ST_DIV) begin
            add_a  = {acc_q, quo_q[31]};
            add_b  = ~{1'b0, opa_q};
            add_ci = 1'b1;
        end
        add_s = {1'b0, add_a} + {1'b0, add_b} + {33'd0, add_ci};
    end

    assign prod     = {acc_q, quo_q};
    assign prod_fix = (s1n_q ^ s2n_q) ? -prod : prod;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Hi     <= '0;
            Lo     <= '0;
            acc_q  <= '0;
            quo_q  <= '0;
            opa_q  <= '0;
            cnt_q  <= '0;
            op_q   <= MDUOp_MULT;
            s1n_q  <= 1'b0;
            s2n_q  <= 1'b0;
            dz_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (Flush) begin
                cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_ok && op_in == MDUOp_MTHI) begin
                            Hi     <= Src1;
                            done_q <= 1'b1;
                        end else if (start_ok && op_in == MDUOp_MTLO) begin
                            Lo     <= Src1;
                            done_q <= 1'b1;
                        end else if (start_ok && (go_mul || go_div)) begin
                            op_q  <= op_in;
                            acc_q <= '0;
                            cnt_q <= '0;
                            s1n_q <= signed_in & Src1[31];
                            s2n_q <= signed_in & Src2[31];
                            dz_q  <= (Src2 == 32'd0);
                            opa_q <= go_div ? mdu_mag(Src2, signed_in) : mdu_mag(Src1, signed_in);
                            quo_q <= go_div ? mdu_mag(Src1, signed_in) : mdu_mag(Src2, signed_in);
                        end
                    end
                    ST_MUL: begin
                        if (!cnt_last) begin
                            acc_q <= add_s[32:1];
                            quo_q <= {add_s[0], quo_q[31:1]};
                            cnt_q <= cnt_q + MDU_CNT_W'(1);
                        end else begin
                            cnt_q <= '0;
                            if (is_acc_q) begin
                                {acc_q, quo_q} <= prod_fix;
                            end else begin
                                {Hi, Lo} <= prod_fix;
                                done_q   <= 1'b1;
                            end
                        end
                    end
                    ST_DIV: begin
                        if (!cnt_last) begin
                            if (add_s[33]) begin
                                acc_q <= add_s[31:0];
                                quo_q <= {quo_q[30:0], 1'b1};
                            end else begin
                                acc_q <= {acc_q[30:0], quo_q[31]};
                                quo_q <= {quo_q[30:0], 1'b0};
                            end
                            cnt_q <= cnt_q + MDU_CNT_W'(1);
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    ST_FIX: begin
                        done_q <= 1'b1;
`ifdef MDU_MADD_EN
                        if (is_acc_q) begin
                            {Hi, Lo} <= (op_q == MDUOp_MSUB) ? ({Hi, Lo} - prod) : ({Hi, Lo} + prod);
                        end else
`endif
                        begin
                            // Remainder follows the dividend; divide-by-zero forces an all-ones quotient.
                            Hi <= s1n_q ? -acc_q : acc_q;
                            Lo <= dz_q ? 32'hFFFF_FFFF : ((s1n_q ^ s2n_q) ? -quo_q : quo_q);
                        end
                    end
                    default: cnt_q <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// against an arithmetic HI/LO model.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

`ifdef MDU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset_n, Start, Flush;
    logic [2:0]  Op;
    logic [31:0] Src1, Src2;
    logic        Busy, Done;
    logic [31:0] Hi, Lo;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m_hi, m_lo;

    muldiv_unit dut (
        .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Op(Op),
        .Src1(Src1), .Src2(Src2), .Flush(Flush),
        .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Architectural result of an op on the current {hi,lo}.
    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
        case (op)
            3'd0: return p;
            3'd1: return {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd3: return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            3'd4: return {a, lo};
            3'd5: return {hi, a};
            3'd6: return MADD_EN ? ({hi, lo} + p) : {hi, lo};
            default: return MADD_EN ? ({hi, lo} - p) : {hi, lo};
        endcase
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit poke);
        logic [63:0] exp;
        int cyc, lat;
        exp  = ref_op(op, a, b, m_hi, m_lo);
        Op   = op; Src1 = a; Src2 = b; Start = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Start = 1'b0; Src1 = $urandom; Src2 = $urandom; Op = 3'($urandom);
        if (op == MDUOp_MTHI || op == MDUOp_MTLO) begin
            chk("mt_done", 64'(Done), 64'd1);
            chk("mt_busy", 64'(Busy), 64'd0);
            chk("mt_hilo", {Hi, Lo}, exp);
        end else if (!MADD_EN && op >= 3'd6) begin
            chk("ign_busy", 64'(Busy), 64'd0);
            chk("ign_done", 64'(Done), 64'd0);
            chk("ign_hilo", {Hi, Lo}, exp);
        end else begin
            lat = (op == MDUOp_MULT || op == MDUOp_MULTU) ? 33 : 34;
            chk("busy_rise", 64'(Busy), 64'd1);
            chk("hold_hilo", {Hi, Lo}, {m_hi, m_lo});
            cyc = 0;
            while (!Done && cyc < 60) begin
                @(negedge Clock);
                cyc++;
                if (poke && cyc == 5) begin
                    Start = 1'b1; Op = MDUOp_MTHI; Src1 = $urandom;
                end else begin
                    Start = 1'b0;
                end
            end
            chk("latency", 64'(cyc), 64'(lat));
            chk("done_busy", 64'(Busy), 64'd0);
            chk("result", {Hi, Lo}, exp);
        end
        {m_hi, m_lo} = exp;
    endtask

    initial begin
        int cyc;
        bit seen;
        logic [2:0] rop;
        Reset_n = 1'b0; Start = 1'b0; Flush = 1'b0; Op = '0; Src1 = '0; Src2 = '0;
        m_hi = '0; m_lo = '0;
        #1;
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_hilo", {Hi, Lo}, 64'd0);
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        @(negedge Clock);

        // Directed corner cases, issued back to back (each Start lands in the previous Done cycle).
        run_op(MDUOp_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("mult_ex", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(MDUOp_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        chk("div_ex", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(MDUOp_DIVU, 32'd7, 32'd0, 1'b0);
        chk("divu_z", {Hi, Lo}, 64'h0000_0007_FFFF_FFFF);
        run_op(MDUOp_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf", {Hi, Lo}, 64'h0000_0000_8000_0000);
        run_op(MDUOp_DIV, 32'hFFFF_FFFB, 32'd0, 1'b0);
        run_op(MDUOp_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(MDUOp_MTHI, 32'd0, 32'd0, 1'b0);
        run_op(MDUOp_MTLO, 32'd5, 32'd0, 1'b0);
        run_op(MDUOp_MADD, 32'd2, 32'd3, 1'b0);
        if (MADD_EN) chk("madd_ex", {Hi, Lo}, 64'd11);
        run_op(MDUOp_MSUB, 32'hFFFF_FFFD, 32'd4, 1'b0);

        // Flush mid-multiply: back to idle next edge, no Done, HI/LO untouched.
        Op = MDUOp_MULTU; Src1 = $urandom; Src2 = $urandom; Start = 1'b1;
        @(posedge Clock); @(negedge Clock);
        Start = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge Clock);
        Flush = 1'b1;
        @(negedge Clock);
        Flush = 1'b0;
        chk("flush_busy", 64'(Busy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clock);
            if (Done) seen = 1'b1;
        end
        chk("flush_nodone", 64'(seen), 64'd0);
        chk("flush_hilo", {Hi, Lo}, {m_hi, m_lo});

        // Flush beats a simultaneous Start.
        Op = MDUOp_MTHI; Src1 = ~m_hi; Start = 1'b1; Flush = 1'b1;
        @(posedge Clock); @(negedge Clock);
        Start = 1'b0; Flush = 1'b0;
        chk("fs_done", 64'(Done), 64'd0);
        chk("fs_hilo", {Hi, Lo}, {m_hi, m_lo});

        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            run_op(rop, rnd_val(), rnd_val(), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a divide.
        Op = MDUOp_DIV; Src1 = $urandom; Src2 = $urandom; Start = 1'b1;
        @(posedge Clock); @(negedge Clock);
        Start = 1'b0;
        for (int i = 0; i < 20; i++) @(negedge Clock);
        Reset_n = 1'b0;
        #1;
        chk("amid_busy", 64'(Busy), 64'd0);
        chk("amid_done", 64'(Done), 64'd0);
        chk("amid_hilo", {Hi, Lo}, 64'd0);
        m_hi = '0; m_lo = '0;
        @(negedge Clock);
        Reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (Done || Busy) seen = 1'b1;
        end
        chk("amid_quiet", 64'(seen), 64'd0);
        run_op(MDUOp_MULT, 32'd6, 32'hFFFF_FFF9, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
